segre_mem_arbiter: RTL and testbench



---
 rtl/segre_pkg.sv | 20 ++
 rtl/segre_icache_lru.sv | 54 +++++
 rtl/segre_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory subsystem.
package segre_pkg;

  localparam int ICACHE_LANE_SIZE  = 128;
  localparam int ICACHE_INDEX_SIZE = 2;
  localparam int LANE_BYTE_SIZE    = 4;

  typedef enum logic [1:0] {
    MMU_IDLE,
    MMU_IC_REQ,
    MMU_DC_REQ,
    MMU_RESP
  } mmu_fsm_state_e;

  typedef enum logic {
    GRANT_IC,
    GRANT_DC
  } grant_e;

endpackage

// File: rtl/segre_icache_lru.sv
// True-LRU age tracker for the icache; ages stay a permutation of 0..N-1
// and the victim is the line holding the oldest age.
module segre_icache_lru #(
  parameter int INDEX_SIZE = 2
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  touch_i,
  input  logic [INDEX_SIZE-1:0] touch_index_i,
  output logic [INDEX_SIZE-1:0] victim_o
);

  localparam int N = 2 ** INDEX_SIZE;

  logic [INDEX_SIZE-1:0] age_q [N];
  logic [INDEX_SIZE-1:0] age_d [N];

  // Lines younger than the touched one age by one; the touched line becomes newest.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_d[i] = age_q[i];
    end
    if (touch_i) begin
      for (int j = 0; j < N; j++) begin
        if (age_q[j] < age_q[touch_index_i]) begin
          age_d[j] = age_q[j] + INDEX_SIZE'(1);
        end
      end
      age_d[touch_index_i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= INDEX_SIZE'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int i = 0; i < N; i++) begin
      if (age_q[i] == INDEX_SIZE'(N - 1)) begin
        victim_o = INDEX_SIZE'(i);
      end
    end
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Arbitrates the single lane-wide memory port between icache fills and dcache
// lane accesses, and owns the icache replacement (LRU) state.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE     = 32,
  parameter int LANE_SIZE     = ICACHE_LANE_SIZE,
  parameter int IC_INDEX_SIZE = ICACHE_INDEX_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic                     ic_miss_i,
  input  logic [ADDR_SIZE-1:0]     ic_addr_i,
  input  logic                     ic_access_i,
  input  logic [IC_INDEX_SIZE-1:0] ic_hit_index_i,
  output logic                     ic_fill_o,
  output logic [LANE_SIZE-1:0]     ic_fill_data_o,
  output logic [IC_INDEX_SIZE-1:0] ic_lru_index_o,
  input  logic                     dc_req_i,
  input  logic                     dc_we_i,
  input  logic [ADDR_SIZE-1:0]     dc_addr_i,
  input  logic [LANE_SIZE-1:0]     dc_wr_data_i,
  output logic                     dc_ack_o,
  output logic [LANE_SIZE-1:0]     dc_rd_data_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_SIZE-1:0]     mem_addr_o,
  output logic [LANE_SIZE-1:0]     mem_wr_data_o,
  input  logic                     mem_ready_i,
  input  logic [LANE_SIZE-1:0]     mem_rd_data_i
);

  localparam int LB = $clog2(LANE_SIZE / 8);
  localparam logic [ADDR_SIZE-1:0] OFFSET_MASK = ADDR_SIZE'((64'd1 << LB) - 64'd1);

  mmu_fsm_state_e state_q, state_d;
  grant_e         last_grant_q, last_grant_d;
  grant_e         grant_sel;
  logic           grant_valid;

  logic [ADDR_SIZE-1:0]     addr_q;
  logic                     we_q;
  logic [LANE_SIZE-1:0]     wdata_q;
  logic [IC_INDEX_SIZE-1:0] victim_q;
  logic [LANE_SIZE-1:0]     ic_fill_data_q;
  logic [LANE_SIZE-1:0]     dc_rd_data_q;

  logic                     in_req;
  logic                     ic_owns;
  logic                     fill_touch;
  logic                     lru_touch;
  logic [IC_INDEX_SIZE-1:0] lru_touch_index;
  logic [IC_INDEX_SIZE-1:0] live_victim;

  // On a tie the requester that was not served last wins, so neither side starves.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_valid  = 1'b0;
    grant_sel    = GRANT_IC;
    case (state_q)
      MMU_IDLE: begin
        if (ic_miss_i && dc_req_i) begin
          grant_valid = 1'b1;
          grant_sel   = (last_grant_q == GRANT_DC) ? GRANT_IC : GRANT_DC;
        end else if (ic_miss_i) begin
          grant_valid = 1'b1;
          grant_sel   = GRANT_IC;
        end else if (dc_req_i) begin
          grant_valid = 1'b1;
          grant_sel   = GRANT_DC;
        end
        if (grant_valid) begin
          last_grant_d = grant_sel;
          state_d      = (grant_sel == GRANT_IC) ? MMU_IC_REQ : MMU_DC_REQ;
        end
      end
      MMU_IC_REQ, MMU_DC_REQ: begin
        if (mem_ready_i) begin
          state_d = MMU_RESP;
        end
      end
      MMU_RESP: state_d = MMU_IDLE;
      default:  state_d = MMU_IDLE;
    endcase
  end

  assign in_req = (state_q == MMU_IC_REQ) || (state_q == MMU_DC_REQ);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q        <= MMU_IDLE;
      last_grant_q   <= GRANT_DC;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      victim_q       <= '0;
      ic_fill_data_q <= '0;
      dc_rd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (grant_valid) begin
        if (grant_sel == GRANT_IC) begin
          addr_q  <= ic_addr_i & ~OFFSET_MASK;
          we_q    <= 1'b0;
          wdata_q <= '0;
        end else begin
          addr_q  <= dc_addr_i & ~OFFSET_MASK;
          we_q    <= dc_we_i;
          wdata_q <= dc_wr_data_i;
        end
        victim_q <= live_victim;
      end
      if (in_req && mem_ready_i) begin
        if (state_q == MMU_IC_REQ) begin
          ic_fill_data_q <= mem_rd_data_i;
        end else begin
          dc_rd_data_q <= mem_rd_data_i;
        end
      end
    end
  end

  assign mem_req_o     = in_req;
  assign mem_we_o      = in_req ? we_q    : 1'b0;
  assign mem_addr_o    = in_req ? addr_q  : '0;
  assign mem_wr_data_o = in_req ? wdata_q : '0;

  assign ic_fill_o      = (state_q == MMU_RESP) && (last_grant_q == GRANT_IC);
  assign dc_ack_o       = (state_q == MMU_RESP) && (last_grant_q == GRANT_DC);
  assign ic_fill_data_o = ic_fill_data_q;
  assign dc_rd_data_o   = dc_rd_data_q;

  // While a fill is in flight the IF stage must see the victim chosen at grant time.
  assign ic_owns        = (state_q == MMU_IC_REQ) || ic_fill_o;
  assign ic_lru_index_o = ic_owns ? victim_q : live_victim;

  assign fill_touch      = ic_fill_o;
  assign lru_touch       = fill_touch || (ic_access_i && !ic_miss_i);
  assign lru_touch_index = fill_touch ? victim_q : ic_hit_index_i;

  segre_icache_lru #(
    .INDEX_SIZE (IC_INDEX_SIZE)
  ) u_lru (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .touch_i       (lru_touch),
    .touch_index_i (lru_touch_index),
    .victim_o      (live_victim)
  );

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed-vector bench for segre_mem_arbiter; each scenario task checks its own expectations.
module tb_segre_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rsn_i;
  logic         ic_miss_i;
  logic [31:0]  ic_addr_i;
  logic         ic_access_i;
  logic [1:0]   ic_hit_index_i;
  logic         ic_fill_o;
  logic [127:0] ic_fill_data_o;
  logic [1:0]   ic_lru_index_o;
  logic         dc_req_i;
  logic         dc_we_i;
  logic [31:0]  dc_addr_i;
  logic [127:0] dc_wr_data_i;
  logic         dc_ack_o;
  logic [127:0] dc_rd_data_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wr_data_o;
  logic         mem_ready_i;
  logic [127:0] mem_rd_data_i;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [127:0] FILL1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] FILL2 = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] RDAT  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] A5    = {16{8'hA5}};

  segre_mem_arbiter dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .ic_miss_i      (ic_miss_i),
    .ic_addr_i      (ic_addr_i),
    .ic_access_i    (ic_access_i),
    .ic_hit_index_i (ic_hit_index_i),
    .ic_fill_o      (ic_fill_o),
    .ic_fill_data_o (ic_fill_data_o),
    .ic_lru_index_o (ic_lru_index_o),
    .dc_req_i       (dc_req_i),
    .dc_we_i        (dc_we_i),
    .dc_addr_i      (dc_addr_i),
    .dc_wr_data_i   (dc_wr_data_i),
    .dc_ack_o       (dc_ack_o),
    .dc_rd_data_o   (dc_rd_data_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_ready_i    (mem_ready_i),
    .mem_rd_data_i  (mem_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rsn_i          = 1'b0;
    ic_miss_i      = 1'b0;
    ic_addr_i      = '0;
    ic_access_i    = 1'b0;
    ic_hit_index_i = '0;
    dc_req_i       = 1'b0;
    dc_we_i        = 1'b0;
    dc_addr_i      = '0;
    dc_wr_data_i   = '0;
    mem_ready_i    = 1'b0;
    mem_rd_data_i  = '0;
    tick();
    tick();
    rsn_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checkCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mem_req: got %b want 0", mem_req_o); end
    checkCount++; if (mem_addr_o !== 32'h0) begin failCount++; $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr_o); end
    checkCount++; if (ic_lru_index_o !== 2'd3) begin failCount++; $display("[TB] FAIL rst_lru: got %0d want 3", ic_lru_index_o); end
    checkCount++; if (ic_fill_o !== 1'b0 || dc_ack_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_strobes: got fill=%b ack=%b want 0/0", ic_fill_o, dc_ack_o); end
    checkCount++; if (ic_fill_data_o !== 128'h0 || dc_rd_data_o !== 128'h0) begin failCount++; $display("[TB] FAIL rst_data: got %h / %h want 0", ic_fill_data_o, dc_rd_data_o); end
    tick();
    checkCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL idle_no_req: got %b want 0", mem_req_o); end
  endtask

  task automatic test_ic_fill();
    do_reset();
    ic_miss_i = 1'b1;
    ic_addr_i = 32'h0000_1234;
    tick();
    checkCount++; if (mem_req_o !== 1'b1) begin failCount++; $display("[TB] FAIL fill_req: got %b want 1", mem_req_o); end
    checkCount++; if (mem_addr_o !== 32'h0000_1230) begin failCount++; $display("[TB] FAIL fill_addr: got %h want 00001230", mem_addr_o); end
    checkCount++; if (mem_we_o !== 1'b0) begin failCount++; $display("[TB] FAIL fill_we: got %b want 0", mem_we_o); end
    checkCount++; if (ic_lru_index_o !== 2'd3) begin failCount++; $display("[TB] FAIL fill_lru_req: got %0d want 3", ic_lru_index_o); end
    tick();
    checkCount++; if (ic_fill_o !== 1'b0 || mem_addr_o !== 32'h0000_1230) begin failCount++; $display("[TB] FAIL fill_wait: got fill=%b addr=%h want 0/00001230", ic_fill_o, mem_addr_o); end
    mem_ready_i   = 1'b1;
    mem_rd_data_i = FILL1;
    tick();
    mem_ready_i   = 1'b0;
    mem_rd_data_i = '0;
    checkCount++; if (ic_fill_o !== 1'b1) begin failCount++; $display("[TB] FAIL fill_strobe: got %b want 1", ic_fill_o); end
    checkCount++; if (ic_fill_data_o !== FILL1) begin failCount++; $display("[TB] FAIL fill_data: got %h want %h", ic_fill_data_o, FILL1); end
    checkCount++; if (ic_lru_index_o !== 2'd3) begin failCount++; $display("[TB] FAIL fill_lru_resp: got %0d want 3", ic_lru_index_o); end
    checkCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL fill_resp_req: got %b want 0", mem_req_o); end
    ic_miss_i = 1'b0;
    tick();
    checkCount++; if (ic_fill_o !== 1'b0) begin failCount++; $display("[TB] FAIL fill_one_cycle: got %b want 0", ic_fill_o); end
    checkCount++; if (ic_fill_data_o !== FILL1) begin failCount++; $display("[TB] FAIL fill_data_hold: got %h want %h", ic_fill_data_o, FILL1); end
    checkCount++; if (ic_lru_index_o !== 2'd2) begin failCount++; $display("[TB] FAIL fill_lru_after: got %0d want 2", ic_lru_index_o); end
  endtask

  task automatic test_tie();
    do_reset();
    ic_miss_i    = 1'b1;
    ic_addr_i    = 32'h0000_2004;
    dc_req_i     = 1'b1;
    dc_we_i      = 1'b1;
    dc_addr_i    = 32'h0000_0080;
    dc_wr_data_i = A5;
    tick();
    checkCount++; if (mem_addr_o !== 32'h0000_2000 || mem_we_o !== 1'b0) begin failCount++; $display("[TB] FAIL tie_ic_first: got addr=%h we=%b want 00002000/0", mem_addr_o, mem_we_o); end
    mem_ready_i   = 1'b1;
    mem_rd_data_i = FILL2;
    tick();
    mem_ready_i = 1'b0;
    checkCount++; if (ic_fill_o !== 1'b1 || dc_ack_o !== 1'b0) begin failCount++; $display("[TB] FAIL tie_ic_resp: got fill=%b ack=%b want 1/0", ic_fill_o, dc_ack_o); end
    ic_miss_i = 1'b0;
    tick();
    checkCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL tie_idle: got req=%b want 0", mem_req_o); end
    tick();
    checkCount++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_0080) begin failCount++; $display("[TB] FAIL tie_dc_req: got req=%b we=%b addr=%h want 1/1/00000080", mem_req_o, mem_we_o, mem_addr_o); end
    checkCount++; if (mem_wr_data_o !== A5) begin failCount++; $display("[TB] FAIL tie_dc_wdata: got %h want %h", mem_wr_data_o, A5); end
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    checkCount++; if (dc_ack_o !== 1'b1 || ic_fill_o !== 1'b0) begin failCount++; $display("[TB] FAIL tie_dc_ack: got ack=%b fill=%b want 1/0", dc_ack_o, ic_fill_o); end
    // A fresh tie raised during RESP must go back to the icache.
    ic_miss_i = 1'b1;
    ic_addr_i = 32'h0000_3010;
    tick();
    checkCount++; if (dc_ack_o !== 1'b0) begin failCount++; $display("[TB] FAIL tie_ack_one_cycle: got %b want 0", dc_ack_o); end
    tick();
    checkCount++; if (mem_addr_o !== 32'h0000_3010 || mem_we_o !== 1'b0) begin failCount++; $display("[TB] FAIL tie_alternate: got addr=%h we=%b want 00003010/0", mem_addr_o, mem_we_o); end
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    ic_miss_i   = 1'b0;
    dc_req_i    = 1'b0;
    tick();
  endtask

  task automatic test_lru_hits();
    do_reset();
    ic_access_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ic_hit_index_i = 2'(k);
      tick();
      if (k == 2) begin
        checkCount++; if (ic_lru_index_o !== 2'd3) begin failCount++; $display("[TB] FAIL lru_mid: got %0d want 3", ic_lru_index_o); end
      end
    end
    ic_access_i = 1'b0;
    checkCount++; if (ic_lru_index_o !== 2'd0) begin failCount++; $display("[TB] FAIL lru_hits: got %0d want 0", ic_lru_index_o); end
    ic_access_i    = 1'b1;
    ic_hit_index_i = 2'd0;
    ic_miss_i      = 1'b1;
    tick();
    checkCount++; if (ic_lru_index_o !== 2'd0) begin failCount++; $display("[TB] FAIL lru_miss_no_touch: got %0d want 0", ic_lru_index_o); end
    ic_miss_i   = 1'b0;
    ic_access_i = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    dc_req_i  = 1'b1;
    dc_we_i   = 1'b0;
    dc_addr_i = 32'h0000_ABCD;
    tick();
    ic_miss_i = 1'b1;
    ic_addr_i = 32'h0000_4440;
    for (int i = 0; i < 10; i++) begin
      checkCount++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_ABC0) begin failCount++; $display("[TB] FAIL stall_hold[%0d]: got req=%b addr=%h want 1/0000abc0", i, mem_req_o, mem_addr_o); end
      checkCount++; if (dc_ack_o !== 1'b0 || ic_fill_o !== 1'b0) begin failCount++; $display("[TB] FAIL stall_no_strobe[%0d]: got ack=%b fill=%b want 0/0", i, dc_ack_o, ic_fill_o); end
      tick();
    end
    mem_ready_i   = 1'b1;
    mem_rd_data_i = RDAT;
    tick();
    mem_ready_i   = 1'b0;
    mem_rd_data_i = '0;
    dc_req_i      = 1'b0;
    checkCount++; if (dc_ack_o !== 1'b1 || dc_rd_data_o !== RDAT) begin failCount++; $display("[TB] FAIL stall_ack: got ack=%b data=%h want 1/%h", dc_ack_o, dc_rd_data_o, RDAT); end
    tick();
    tick();
    checkCount++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_4440) begin failCount++; $display("[TB] FAIL stall_ic_next: got req=%b addr=%h want 1/00004440", mem_req_o, mem_addr_o); end
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    ic_miss_i   = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dc_req_i     = 1'b1;
    dc_we_i      = 1'b1;
    dc_addr_i    = 32'h0000_0040;
    dc_wr_data_i = A5;
    tick();
    checkCount++; if (mem_req_o !== 1'b1) begin failCount++; $display("[TB] FAIL rmid_req: got %b want 1", mem_req_o); end
    #2;
    rsn_i = 1'b0;
    #1;
    checkCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_async_drop: got %b want 0", mem_req_o); end
    dc_req_i = 1'b0;
    tick();
    rsn_i       = 1'b1;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++; if (dc_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_quiet[%0d]: got ack=%b req=%b want 0/0", i, dc_ack_o, mem_req_o); end
    end
    mem_ready_i = 1'b0;
    checkCount++; if (ic_lru_index_o !== 2'd3) begin failCount++; $display("[TB] FAIL rmid_lru: got %0d want 3", ic_lru_index_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dc_req_i  = 1'b1;
    dc_we_i   = 1'b0;
    dc_addr_i = 32'h0000_0100;
    tick();
    mem_ready_i   = 1'b1;
    mem_rd_data_i = RDAT;
    tick();
    checkCount++; if (dc_ack_o !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_first_ack: got %b want 1", dc_ack_o); end
    tick();
    checkCount++; if (dc_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_idle_gap: got ack=%b req=%b want 0/0", dc_ack_o, mem_req_o); end
    tick();
    checkCount++; if (mem_req_o !== 1'b1 || dc_ack_o !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_second_req: got req=%b ack=%b want 1/0", mem_req_o, dc_ack_o); end
    tick();
    checkCount++; if (dc_ack_o !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_second_ack: got %b want 1", dc_ack_o); end
    dc_req_i    = 1'b0;
    mem_ready_i = 1'b0;
    tick();
    checkCount++; if (dc_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_done: got ack=%b req=%b want 0/0", dc_ack_o, mem_req_o); end
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_tie();
    test_lru_hits();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
